// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the PSRAM / NOR-flash bus controller.
package mem_bus_pkg;

  // Controller states; INIT is entered on reset and runs the flash reset-release.
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_STSWAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_ERR
  } state_e;

  // Device select encoding on req_sel.
  localparam logic SEL_RAM = 1'b0;
  localparam logic SEL_ROM = 1'b1;

  // Width of the shared wait timer; large enough for the reset, timeout and access counts.
  localparam int TMR_W = 16;

  // Number of ACCESS cycles for a given device/operation. ROM writes never reach
  // ACCESS, so the ROM branch only has to cover reads.
  function automatic logic [TMR_W-1:0] access_cycles(
    input logic sel,
    input logic we,
    input int   ram_rd_ws,
    input int   ram_wr_ws,
    input int   rom_rd_ws
  );
    int ws;
    if (sel == SEL_ROM) begin
      ws = rom_rd_ws;
    end else if (we) begin
      ws = ram_wr_ws;
    end else begin
      ws = ram_rd_ws;
    end
    return TMR_W'(ws);
  endfunction

endpackage

// File: rtl/mem_bus_controller_timer.sv
// Loadable down-counter with a zero flag. One instance is time-shared between
// the flash reset-release, the flash busy-wait timeout and the access wait states.
module mem_wait_timer #(
  parameter int              W       = 16,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; decrement saturates at zero so done stays asserted.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register; the reset value lets INIT start counting without a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_controller.sv
// Request-port to async-bus controller for the board PSRAM (async mode) and
// parallel NOR flash. A single FSM sequences SETUP / ACCESS / HOLD bus phases,
// steers byte lanes and handles flash reset release and busy-wait.
module mem_bus_controller
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 16,
  parameter int RAM_RD_WS   = 7,
  parameter int RAM_WR_WS   = 7,
  parameter int ROM_RD_WS   = 11,
  parameter int RP_CYCLES   = 50,
  parameter int STS_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W:0]   req_addr,
  input  logic              req_we,
  input  logic              req_sel,
  input  logic              req_byte,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_ack,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_dq,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_lb_n,
  output logic              mem_ub_n,
  output logic              ram_ce_n,
  output logic              ram_adv_n,
  output logic              ram_clk,
  output logic              ram_cre,
  output logic              flash_ce_n,
  output logic              flash_rp_n,
  input  logic              flash_sts
);

  localparam int LANES = DATA_W / 8;
  localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(RP_CYCLES - 1);
  localparam logic [TMR_W-1:0] STS_LOAD = TMR_W'(STS_TIMEOUT - 1);

  state_e state_q, state_d;

  // Latched request fields
  logic              sel_q;
  logic              we_q;
  logic              byte_q;
  logic [ADDR_W:0]   addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              latch_req;
  logic              capture_rd;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_load_val;
  logic              tmr_dec;
  logic              tmr_done;

  logic              bus_active;
  logic              in_access;
  logic [LANES-1:0]  lane_en;
  logic [DATA_W-1:0] wr_lane;
  logic              dq_oe;

  mem_wait_timer #(
    .W       (TMR_W),
    .RST_VAL (RP_LOAD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  // State register; reset restarts the flash reset-release sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and timer control.
  always_comb begin
    state_d      = state_q;
    latch_req    = 1'b0;
    capture_rd   = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          latch_req = 1'b1;
          if ((req_sel == SEL_ROM) && req_we) begin
            state_d = ST_ERR;
          end else if ((req_sel == SEL_ROM) && !flash_sts) begin
            tmr_load     = 1'b1;
            tmr_load_val = STS_LOAD;
            state_d      = ST_STSWAIT;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_STSWAIT: begin
        if (flash_sts) begin
          state_d = ST_SETUP;
        end else if (tmr_done) begin
          state_d = ST_ERR;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SETUP: begin
        // Counter holds WS-1 .. 0 across the ACCESS phase.
        tmr_load     = 1'b1;
        tmr_load_val = access_cycles(sel_q, we_q, RAM_RD_WS, RAM_WR_WS, ROM_RD_WS) - TMR_W'(1);
        state_d      = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (tmr_done) begin
          capture_rd = !we_q;
          state_d    = ST_HOLD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Request field capture on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= SEL_RAM;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch_req) begin
      sel_q   <= req_sel;
      we_q    <= req_we;
      byte_q  <= req_byte;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Read data capture on the last ACCESS cycle; byte reads return the addressed lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (capture_rd) begin
      if (byte_q) begin
        rdata_q <= {{(DATA_W-8){1'b0}}, mem_dq[{addr_q[0], 3'b000} +: 8]};
      end else begin
        rdata_q <= mem_dq;
      end
    end
  end

  // Byte-lane steering: word accesses use every lane, byte accesses use the lane
  // picked by address bit 0 and replicate the low write byte onto all lanes.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_en[gi]         = !byte_q || (addr_q[0] == 1'(gi));
    assign wr_lane[gi*8 +: 8]  = byte_q ? wdata_q[7:0] : wdata_q[gi*8 +: 8];
  end

  assign bus_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign in_access  = (state_q == ST_ACCESS);
  assign dq_oe      = bus_active && we_q;

  assign mem_dq     = dq_oe ? wr_lane : {DATA_W{1'bz}};
  assign mem_addr   = addr_q[ADDR_W:1];
  assign mem_oe_n   = !(in_access && !we_q);
  assign mem_we_n   = !(in_access && we_q);
  assign mem_lb_n   = !(in_access && lane_en[0]);
  assign mem_ub_n   = !(in_access && lane_en[1]);
  assign ram_ce_n   = !(bus_active && (sel_q == SEL_RAM));
  assign ram_adv_n  = !(bus_active && (sel_q == SEL_RAM));
  assign flash_ce_n = !(bus_active && (sel_q == SEL_ROM));
  assign flash_rp_n = (state_q != ST_INIT);
  assign ram_clk    = 1'b0;
  assign ram_cre    = 1'b0;

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_ack    = (state_q == ST_HOLD);
  assign rsp_err    = (state_q == ST_ERR);
  assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Bench for mem_bus_controller: bus device models for PSRAM and flash, a
// byte-addressed reference memory, a directed vector table, hand-written
// multi-cycle sequences and randomized transactions.
module tb_mem_bus_controller;

  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 16;
  localparam int RAM_RD_WS   = 8;
  localparam int RAM_WR_WS   = 7;
  localparam int ROM_RD_WS   = 11;
  localparam int RP_CYCLES   = 50;
  localparam int STS_TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W:0]   req_addr;
  logic              req_we;
  logic              req_sel;
  logic              req_byte;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_ack;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  wire  [DATA_W-1:0] mem_dq;
  logic              mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;
  logic              ram_ce_n, ram_adv_n, ram_clk, ram_cre;
  logic              flash_ce_n, flash_rp_n;
  logic              flash_sts;

  always #5 clk = ~clk;

  mem_bus_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_RD_WS(RAM_RD_WS), .RAM_WR_WS(RAM_WR_WS),
    .ROM_RD_WS(ROM_RD_WS), .RP_CYCLES(RP_CYCLES), .STS_TIMEOUT(STS_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_sel(req_sel), .req_byte(req_byte),
    .req_wdata(req_wdata), .rsp_ack(rsp_ack), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_dq(mem_dq), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n), .ram_ce_n(ram_ce_n), .ram_adv_n(ram_adv_n),
    .ram_clk(ram_clk), .ram_cre(ram_cre), .flash_ce_n(flash_ce_n), .flash_rp_n(flash_rp_n),
    .flash_sts(flash_sts)
  );

  // ---------------- device models ----------------
  function automatic logic [15:0] rom_word(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  logic [15:0] dev_ram [0:4095] = '{default: 16'h0000};
  logic        dev_drive;
  logic [15:0] dev_rdata;
  logic        probe_en = 1'b0;

  assign dev_drive = !mem_oe_n && (!ram_ce_n || !flash_ce_n);
  assign dev_rdata = !ram_ce_n ? dev_ram[mem_addr[11:0]] : rom_word(mem_addr);
  // The probe drives zero onto an otherwise released bus so a stray DUT driver shows up.
  assign mem_dq = dev_drive ? dev_rdata : (probe_en ? 16'h0000 : 16'hzzzz);

  always @(posedge clk) begin
    if (!ram_ce_n && !mem_we_n) begin
      if (!mem_lb_n) dev_ram[mem_addr[11:0]][7:0]  <= mem_dq[7:0];
      if (!mem_ub_n) dev_ram[mem_addr[11:0]][15:8] <= mem_dq[15:8];
    end
  end

  // Bus-rule monitor: {both CEs low, flash write strobe, ram_clk/cre high, strobe without CE, OE+WE together}
  logic [4:0] viol = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (!ram_ce_n && !flash_ce_n)                          viol[4] <= 1'b1;
      if (!flash_ce_n && !mem_we_n)                          viol[3] <= 1'b1;
      if (ram_clk || ram_cre)                                viol[2] <= 1'b1;
      if ((!mem_we_n || !mem_oe_n) && ram_ce_n && flash_ce_n) viol[1] <= 1'b1;
      if (!mem_we_n && !mem_oe_n)                            viol[0] <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:8191] = '{default: 8'h00};
  logic [15:0] last_rdata = 16'h0000;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction driver ----------------
  int               obs_lat;
  logic             obs_ack, obs_err, obs_after, obs_ready_after;
  logic [15:0]      obs_rdata, obs_dq;
  int               obs_strb;
  logic             obs_lb_n, obs_ub_n, obs_ram_ce, obs_rom_ce, obs_adv_n;
  logic [ADDR_W-1:0] obs_addr;

  task automatic wait_ready(input string name);
    int w = 0;
    while (!req_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check({name, "_ready"}, req_ready, 1'b1);
  endtask

  task automatic do_req(input string name, input logic sel, input logic we, input logic byt,
                        input logic [23:0] addr, input logic [15:0] wd, input int sts_rise);
    int cyc;
    bit done;
    bit seen_ce;
    wait_ready(name);
    req_valid = 1'b1; req_sel = sel; req_we = we; req_byte = byt;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; done = 0; seen_ce = 0;
    obs_lat = -1; obs_ack = 0; obs_err = 0; obs_rdata = 'x; obs_dq = 'x; obs_strb = 0;
    obs_lb_n = 1; obs_ub_n = 1; obs_ram_ce = 0; obs_rom_ce = 0; obs_adv_n = 1; obs_addr = '0;
    while (!done && cyc <= 3000) begin
      if (cyc == sts_rise) flash_sts = 1'b1;
      if (!seen_ce && (!ram_ce_n || !flash_ce_n)) begin
        seen_ce    = 1;
        obs_addr   = mem_addr;
        obs_ram_ce = !ram_ce_n;
        obs_rom_ce = !flash_ce_n;
        obs_adv_n  = ram_adv_n;
        obs_dq     = mem_dq;
      end
      if (!mem_we_n || !mem_oe_n) begin
        obs_strb++;
        obs_lb_n = mem_lb_n;
        obs_ub_n = mem_ub_n;
      end
      if (rsp_ack || rsp_err) begin
        obs_ack = rsp_ack; obs_err = rsp_err; obs_rdata = rsp_rdata; obs_lat = cyc;
        done = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    @(negedge clk);
    obs_after = rsp_ack || rsp_err;
    obs_ready_after = req_ready;
  endtask

  // Compares the last transaction against what the spec rules predict and
  // updates the reference memory.
  task automatic model_check(input string name, input logic sel, input logic we, input logic byt,
                             input logic [23:0] addr, input logic [15:0] wd, input int extra);
    int ws;
    logic [15:0] w;
    if (sel && we) begin
      check({name, "_ack_err"}, {obs_ack, obs_err}, 2'b01);
      check({name, "_lat"}, obs_lat, 1);
      check({name, "_no_ce"}, {obs_ram_ce, obs_rom_ce}, 2'b00);
      check({name, "_no_strobe"}, obs_strb, 0);
    end else begin
      ws = sel ? ROM_RD_WS : (we ? RAM_WR_WS : RAM_RD_WS);
      check({name, "_ack_err"}, {obs_ack, obs_err}, 2'b10);
      check({name, "_lat"}, obs_lat, ws + 2 + extra);
      check({name, "_strobe_cycles"}, obs_strb, ws);
      check({name, "_mem_addr"}, obs_addr, addr[23:1]);
      check({name, "_ce"}, {obs_ram_ce, obs_rom_ce}, sel ? 2'b01 : 2'b10);
      check({name, "_adv_n"}, obs_adv_n, sel);
      check({name, "_lanes"}, {obs_lb_n, obs_ub_n}, {byt & addr[0], byt & ~addr[0]});
      if (we) begin
        check({name, "_wdq"}, obs_dq, byt ? {wd[7:0], wd[7:0]} : wd);
        if (byt) begin
          ref_mem[addr[12:0]] = wd[7:0];
        end else begin
          ref_mem[{addr[12:1], 1'b0}] = wd[7:0];
          ref_mem[{addr[12:1], 1'b1}] = wd[15:8];
        end
      end else if (sel) begin
        w = rom_word(addr[23:1]);
        last_rdata = byt ? {8'h00, (addr[0] ? w[15:8] : w[7:0])} : w;
      end else begin
        last_rdata = byt ? {8'h00, ref_mem[addr[12:0]]}
                         : {ref_mem[{addr[12:1], 1'b1}], ref_mem[{addr[12:1], 1'b0}]};
      end
      check({name, "_rdata"}, obs_rdata, last_rdata);
    end
    check({name, "_pulse_end"}, {obs_after, obs_ready_after}, 2'b01);
    $display("txn %s sel=%0d we=%0d byte=%0d addr=0x%06h wdata=0x%04h ack=%0d err=%0d lat=%0d rdata=0x%04h",
             name, sel, we, byt, addr, wd, obs_ack, obs_err, obs_lat, obs_rdata);
  endtask

  // Checks reset values while rst is high, then releases it and times the flash reset-release.
  task automatic check_init(input string tag);
    int cyc, ready_early, strobe_seen;
    @(negedge clk);
    probe_en = 1'b1;
    #1;
    check({tag, "_rst_rp_n"}, flash_rp_n, 1'b0);
    check({tag, "_rst_strobes"},
          {mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n, ram_ce_n, ram_adv_n, flash_ce_n}, 7'h7F);
    check({tag, "_rst_zero_outs"}, {ram_clk, ram_cre, req_ready, rsp_ack, rsp_err}, 5'b0);
    check({tag, "_rst_rdata"}, rsp_rdata, 16'h0000);
    check({tag, "_rst_mem_addr"}, mem_addr, 0);
    check({tag, "_rst_dq_released"}, mem_dq, 16'h0000);
    probe_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc = 1; ready_early = 0; strobe_seen = 0;
    while (flash_rp_n == 1'b0 && cyc < 500) begin
      if (req_ready) ready_early++;
      if ({mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n, ram_ce_n, flash_ce_n} != 6'h3F) strobe_seen++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_rp_low_cycles"}, cyc - 1, RP_CYCLES);
    check({tag, "_ready_after_rp"}, req_ready, 1'b1);
    check({tag, "_ready_early"}, ready_early, 0);
    check({tag, "_init_strobes"}, strobe_seen, 0);
    $display("txn %s init rp_low=%0d", tag, cyc - 1);
  endtask

  typedef struct {
    logic        sel;
    logic        we;
    logic        byt;
    logic [23:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rdata;
    int          exp_lat;
    logic [1:0]  exp_ack_err;
    logic [1:0]  exp_lanes;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #500_000;
    $display("FAIL watchdog no completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_sel = 1'b0;
    req_byte = 1'b0; req_wdata = '0; flash_sts = 1'b1;

    //                 sel we byt addr        wdata     rdata     lat ack/err lb/ub
    tbl[0] = '{1'b0, 1'b1, 1'b0, 24'h000100, 16'hBEEF, 16'h0000,  9, 2'b10, 2'b00};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 24'h000100, 16'h0000, 16'hBEEF, 10, 2'b10, 2'b00};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 24'h000101, 16'h005A, 16'hBEEF,  9, 2'b10, 2'b10};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 24'h000101, 16'h0000, 16'h005A, 10, 2'b10, 2'b10};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 24'h000100, 16'hFF33, 16'h005A,  9, 2'b10, 2'b01};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 24'h000100, 16'h0000, 16'h5A33, 10, 2'b10, 2'b00};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 24'h000040, 16'h1234, 16'h5A33,  1, 2'b01, 2'b11};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 24'h000200, 16'h0000, 16'hA4C3, 13, 2'b10, 2'b00};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 24'h000201, 16'h0000, 16'h00A4, 13, 2'b10, 2'b10};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 24'h000200, 16'h0000, 16'h00C3, 13, 2'b10, 2'b01};

    repeat (3) @(posedge clk);
    check_init("por");

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      do_req($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wd, -1);
      model_check($sformatf("tbl%0d_model", i), tbl[i].sel, tbl[i].we, tbl[i].byt,
                  tbl[i].addr, tbl[i].wd, 0);
      check($sformatf("tbl%0d_vec_rdata", i), obs_rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_vec_lat", i), obs_lat, tbl[i].exp_lat);
      check($sformatf("tbl%0d_vec_ack_err", i), {obs_ack, obs_err}, tbl[i].exp_ack_err);
      check($sformatf("tbl%0d_vec_lanes", i), {obs_lb_n, obs_ub_n}, tbl[i].exp_lanes);
    end

    // Flash busy for 20 cycles after accept, then ready: ack 13 cycles later
    flash_sts = 1'b0;
    do_req("stswait", 1'b1, 1'b0, 1'b0, 24'h000404, 16'h0000, 20);
    model_check("stswait_model", 1'b1, 1'b0, 1'b0, 24'h000404, 16'h0000, 20);
    check("stswait_ack_cycle", obs_lat, 33);

    // Flash never ready: request rejected after the timeout
    flash_sts = 1'b0;
    do_req("ststimeout", 1'b1, 1'b0, 1'b1, 24'h000010, 16'h0000, -1);
    check("ststimeout_ack_err", {obs_ack, obs_err}, 2'b01);
    check("ststimeout_lat", obs_lat, STS_TIMEOUT + 1);
    check("ststimeout_no_ce", {obs_ram_ce, obs_rom_ce}, 2'b00);
    check("ststimeout_pulse_end", {obs_after, obs_ready_after}, 2'b01);
    check("ststimeout_rdata_held", obs_rdata, last_rdata);
    $display("txn ststimeout err=%0d lat=%0d", obs_err, obs_lat);
    flash_sts = 1'b1;

    // Reset during a RAM write ACCESS phase
    wait_ready("abort");
    req_valid = 1'b1; req_sel = 1'b0; req_we = 1'b1; req_byte = 1'b0;
    req_addr = 24'h001800; req_wdata = 16'hBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_access", {mem_we_n, ram_ce_n}, 2'b00);
    rst = 1'b1;
    probe_en = 1'b1;
    #1;
    check("abort_strobes_high",
          {mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n, ram_ce_n, ram_adv_n, flash_ce_n}, 7'h7F);
    check("abort_dq_released", mem_dq, 16'h0000);
    check("abort_rp_low", flash_rp_n, 1'b0);
    begin
      int resp = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (rsp_ack || rsp_err) resp++;
      end
      check("abort_no_response", resp, 0);
    end
    $display("txn abort reset asserted during access");
    check_init("abort");
    last_rdata = 16'h0000;

    // Randomized traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      logic        s, w, b;
      logic [23:0] a;
      logic [15:0] d;
      s = ($urandom_range(0, 3) == 0);
      w = s ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = s ? 24'($urandom) : 24'($urandom_range(0, 1023));
      d = 16'($urandom);
      do_req($sformatf("rnd%0d", n), s, w, b, a, d, -1);
      model_check($sformatf("rnd%0d", n), s, w, b, a, d, 0);
    end

    check("bus_rule_violations", viol, 5'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
